ppwm_prog_mem: RTL

Program store and serial loader for the programmable PWM core. It assembles 7-bit instructions from a bit-serial load stream, writes them into a small register-file instruction memory, and serves instruction fetches from the core's program counter. It sits directly upstream of the instruction decode/execute stage, which consumes `instr_o` using the `command_e` opcode layout.

---
 rtl/ppwm_prog_mem.sv | 116 +++++++++++
 1 files changed

// File: rtl/ppwm_prog_mem.sv
// Program store and bit-serial loader for the programmable PWM core.
// Optional readback of the stored program on ser_data_o: define PPWM_PROG_READBACK_EN.
module ppwm_prog_mem #(
    parameter  int unsigned NUM_INSTR = 16,
    localparam int unsigned PC_W      = $clog2(NUM_INSTR)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_en_i,
    input  logic            ser_valid_i,
    input  logic            ser_data_i,
    input  logic [PC_W-1:0] pc_i,
    output logic [6:0]      instr_o,
    output logic [PC_W:0]   prog_len_o,
    output logic            load_done_o,
    output logic            ser_data_o
);

    localparam logic [PC_W:0] FULL_LEN = NUM_INSTR[PC_W:0];

    logic [6:0]      mem_q [NUM_INSTR];
    logic            load_en_q;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [5:0]      shift_q, shift_d;
    logic [PC_W:0]   prog_len_q, prog_len_d;

    logic            load_start;
    logic            accept;
    logic            we;
    logic [2:0]      cnt_base;
    logic [PC_W:0]   len_base;
    logic [6:0]      word;
    logic [PC_W-1:0] waddr;

    // A session start and a strobe on the same edge: clear first, then consume the bit.
    always_comb begin
        load_start = load_en_i & ~load_en_q;
        cnt_base   = load_start ? 3'd0 : bit_cnt_q;
        len_base   = load_start ? '0 : prog_len_q;
        word       = {shift_q, ser_data_i};
        waddr      = len_base[PC_W-1:0];
        accept     = load_en_i & ser_valid_i & (len_base != FULL_LEN);
        we         = 1'b0;
        shift_d    = shift_q;
        bit_cnt_d  = load_en_i ? cnt_base : 3'd0;
        prog_len_d = len_base;
        if (accept) begin
            shift_d = word[5:0];
            if (cnt_base == 3'd6) begin
                we         = 1'b1;
                bit_cnt_d  = 3'd0;
                prog_len_d = len_base + (PC_W + 1)'(1);
            end else begin
                bit_cnt_d = cnt_base + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            load_en_q  <= 1'b0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 6'd0;
            prog_len_q <= '0;
        end else begin
            load_en_q  <= load_en_i;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            prog_len_q <= prog_len_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_INSTR; i++) begin
                mem_q[i] <= 7'h00;
            end
        end else if (we) begin
            mem_q[waddr] <= word;
        end
    end

    assign instr_o     = load_en_i ? 7'h00 : mem_q[pc_i];
    assign prog_len_o  = prog_len_q;
    assign load_done_o = (prog_len_q == FULL_LEN);

`ifdef PPWM_PROG_READBACK_EN
    logic [PC_W-1:0] rb_word_q;
    logic [2:0]      rb_bit_q;
    logic [6:0]      rb_entry;

    // Word pointer wraps on its own since NUM_INSTR is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rb_word_q <= '0;
            rb_bit_q  <= 3'd0;
        end else if (load_en_i) begin
            rb_word_q <= '0;
            rb_bit_q  <= 3'd0;
        end else if (ser_valid_i) begin
            if (rb_bit_q == 3'd6) begin
                rb_bit_q  <= 3'd0;
                rb_word_q <= rb_word_q + PC_W'(1);
            end else begin
                rb_bit_q <= rb_bit_q + 3'd1;
            end
        end
    end

    assign rb_entry   = mem_q[rb_word_q];
    assign ser_data_o = rb_entry[3'd6 - rb_bit_q];
`else
    assign ser_data_o = 1'b0;
`endif

endmodule
